// File: rtl/cxu_rsync_sequencer_pkg.sv
// Shared types and constants for the CXU rsync sequencer.
// Holds the CXU function ids, the FSM state enum and the per-byte metadata bundle.
package cxu_rsync_sequencer_pkg;

  localparam logic [2:0] FN_HASH_UPDATE = 3'd0;
  localparam logic [2:0] FN_RSYNC_ROLL  = 3'd1;

  typedef enum logic [2:0] {
    IDLE,
    HASH_CMD,
    HASH_RSP,
    ROLL_CMD,
    ROLL_RSP,
    EMIT
  } seq_state_e;

  typedef struct packed {
    logic [7:0] new_byte;
    logic [7:0] old_byte;
    logic       last;
  } meta_t;

  // Shift used by the CXU hash update: hash' = ((hash << H_SHIFT) ^ byte) & HASH_MASK
  function automatic int h_shift(input int hash_bits);
    return (hash_bits + 2) / 3;
  endfunction

endpackage

// File: rtl/cxu_rsync_sequencer_if.sv
// Byte-stream, CXU cmd/rsp and result handshakes of the rsync sequencer.
// master = sequencer side, slave = source / CXU / sink side.
interface cxu_rsync_sequencer_if #(
  parameter int HASH_BITS = 15
);
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_byte;
  logic                 in_last;

  logic                 cxu_cmd_valid;
  logic                 cxu_cmd_ready;
  logic [2:0]           cxu_cmd_function_id;
  logic [31:0]          cxu_cmd_inputs_0;
  logic [31:0]          cxu_cmd_inputs_1;
  logic                 cxu_rsp_valid;
  logic                 cxu_rsp_ready;
  logic [31:0]          cxu_rsp_outputs_0;

  logic                 out_valid;
  logic                 out_ready;
  logic [HASH_BITS-1:0] out_hash;
  logic [31:0]          out_sum;
  logic                 out_boundary;
  logic                 out_last;

  modport master (
    input  in_valid, in_byte, in_last,
    output in_ready,
    output cxu_cmd_valid, cxu_cmd_function_id, cxu_cmd_inputs_0, cxu_cmd_inputs_1,
    input  cxu_cmd_ready,
    input  cxu_rsp_valid, cxu_rsp_outputs_0,
    output cxu_rsp_ready,
    output out_valid, out_hash, out_sum, out_boundary, out_last,
    input  out_ready
  );

  modport slave (
    output in_valid, in_byte, in_last,
    input  in_ready,
    input  cxu_cmd_valid, cxu_cmd_function_id, cxu_cmd_inputs_0, cxu_cmd_inputs_1,
    output cxu_cmd_ready,
    output cxu_rsp_valid, cxu_rsp_outputs_0,
    input  cxu_rsp_ready,
    input  out_valid, out_hash, out_sum, out_boundary, out_last,
    output out_ready
  );

endinterface

// File: rtl/cxu_rsync_window_ring.sv
// RSYNC_WIN x 8 history ring with write pointer and saturating fill count; old_byte is 0 until full.
// Push is single-cycle; clear and reset both empty the window (contents are left as-is).
module rsync_window_ring #(
  parameter int RSYNC_WIN = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       push,
  input  logic [7:0] push_byte,
  output logic [7:0] old_byte,
  output logic       full
);
  localparam int WIN_AW = $clog2(RSYNC_WIN);
  localparam logic [WIN_AW:0] FULL_CNT = (WIN_AW + 1)'(RSYNC_WIN);

  logic [7:0]        mem [RSYNC_WIN];
  logic [WIN_AW-1:0] wptr;
  logic [WIN_AW:0]   count;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_byte;
  end

  // Window length is a power of two, so the pointer wraps by natural overflow.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wptr  <= '0;
      count <= '0;
    end else if (push) begin
      wptr <= wptr + 1'b1;
      if (!full) count <= count + 1'b1;
    end
  end

  assign full     = (count == FULL_CNT);
  assign old_byte = full ? mem[wptr] : 8'h00;

endmodule

// File: rtl/cxu_rsync_sequencer.sv
// Per byte: CXU hash update then rsync roll, then emit hash/sum/boundary; 5 cycles accept-to-out, 1 byte/6 cycles.
// Stalls on cmd_ready, rsp_valid and out_ready; in_ready only in IDLE.
module cxu_rsync_sequencer
  import cxu_rsync_sequencer_pkg::*;
#(
  parameter int HASH_BITS = 15,
  parameter int RSYNC_WIN = 4096
) (
  input logic                  clk,
  input logic                  reset,
  cxu_rsync_sequencer_if.master bus
);
  localparam int WIN_AW = $clog2(RSYNC_WIN);

  seq_state_e           state, state_nxt;
  meta_t                meta;
  logic [HASH_BITS-1:0] hash;
  logic [31:0]          sum;
  logic [7:0]           ring_old;
  logic                 win_full;
  logic                 in_fire, out_fire, ring_push, ring_clear;

  assign in_fire    = (state == IDLE) && bus.in_valid;
  assign out_fire   = (state == EMIT) && bus.out_ready;
  assign ring_push  = (state == ROLL_RSP) && bus.cxu_rsp_valid;
  assign ring_clear = out_fire && meta.last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      meta  <= '0;
      hash  <= '0;
      sum   <= '0;
    end else begin
      state <= state_nxt;
      if (in_fire) begin
        meta <= '{new_byte: bus.in_byte, old_byte: ring_old, last: bus.in_last};
      end
      if ((state == HASH_RSP) && bus.cxu_rsp_valid) hash <= bus.cxu_rsp_outputs_0[HASH_BITS-1:0];
      if (ring_push) sum <= bus.cxu_rsp_outputs_0;
      if (ring_clear) begin
        hash <= '0;
        sum  <= '0;
      end
    end
  end

  // Payload stays driven through the RSP states since the CXU may compute combinationally.
  always_comb begin
    state_nxt               = state;
    bus.in_ready            = 1'b0;
    bus.cxu_cmd_valid       = 1'b0;
    bus.cxu_cmd_function_id = FN_HASH_UPDATE;
    bus.cxu_cmd_inputs_0    = '0;
    bus.cxu_cmd_inputs_1    = '0;
    bus.cxu_rsp_ready       = 1'b0;
    bus.out_valid           = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = HASH_CMD;
      end
      HASH_CMD, HASH_RSP: begin
        bus.cxu_cmd_function_id = FN_HASH_UPDATE;
        bus.cxu_cmd_inputs_0    = 32'(hash);
        bus.cxu_cmd_inputs_1    = {24'h0, meta.new_byte};
        if (state == HASH_CMD) begin
          bus.cxu_cmd_valid = 1'b1;
          if (bus.cxu_cmd_ready) state_nxt = HASH_RSP;
        end else begin
          bus.cxu_rsp_ready = 1'b1;
          if (bus.cxu_rsp_valid) state_nxt = ROLL_CMD;
        end
      end
      ROLL_CMD, ROLL_RSP: begin
        bus.cxu_cmd_function_id = FN_RSYNC_ROLL;
        bus.cxu_cmd_inputs_0    = sum;
        bus.cxu_cmd_inputs_1    = {16'h0, meta.old_byte, meta.new_byte};
        if (state == ROLL_CMD) begin
          bus.cxu_cmd_valid = 1'b1;
          if (bus.cxu_cmd_ready) state_nxt = ROLL_RSP;
        end else begin
          bus.cxu_rsp_ready = 1'b1;
          if (bus.cxu_rsp_valid) state_nxt = EMIT;
        end
      end
      EMIT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.out_hash     = hash;
  assign bus.out_sum      = sum;
  assign bus.out_last     = meta.last;
  assign bus.out_boundary = win_full && (sum[WIN_AW-1:0] == '0);

  rsync_window_ring #(
    .RSYNC_WIN(RSYNC_WIN)
  ) u_ring (
    .clk      (clk),
    .reset    (reset),
    .clear    (ring_clear),
    .push     (ring_push),
    .push_byte(meta.new_byte),
    .old_byte (ring_old),
    .full     (win_full)
  );

endmodule

// File: tb/tb_cxu_rsync_sequencer.sv
// Bench for cxu_rsync_sequencer: behavioural CXU with programmable stalls, and a
// window-sum reference model (sum of the last RSYNC_WIN bytes of the current stream).
module tb_cxu_rsync_sequencer;
  localparam int HB = 15;
  localparam int W  = 4;
  localparam int SH = (HB + 2) / 3;
  localparam logic [31:0] MASK = (32'h1 << HB) - 32'h1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cxu_rsync_sequencer_if #(.HASH_BITS(HB)) bus();

  cxu_rsync_sequencer #(.HASH_BITS(HB), .RSYNC_WIN(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // CXU environment: combinational result, ready/valid delayed by a programmable count
  int cmd_delay = 0, rsp_delay = 0, cmd_cnt = 0, rsp_cnt = 0, pay_err = 0;
  bit spurious = 1'b0, prev_active = 1'b0, prev_cmd = 1'b0;
  logic [66:0] prev_pay = '0;

  assign bus.cxu_rsp_outputs_0 = (bus.cxu_cmd_function_id == 3'd0)
      ? (((bus.cxu_cmd_inputs_0 << SH) ^ bus.cxu_cmd_inputs_1) & MASK)
      : (bus.cxu_cmd_inputs_0 - {24'h0, bus.cxu_cmd_inputs_1[15:8]} + {24'h0, bus.cxu_cmd_inputs_1[7:0]});

  always @(negedge clk) begin
    logic [66:0] pay;
    bit held;
    pay  = {bus.cxu_cmd_function_id, bus.cxu_cmd_inputs_0, bus.cxu_cmd_inputs_1};
    held = bus.cxu_rsp_ready || (bus.cxu_cmd_valid && prev_cmd);
    if (!reset && prev_active && held && (pay !== prev_pay)) pay_err++;
    prev_active = bus.cxu_cmd_valid || bus.cxu_rsp_ready;
    prev_cmd    = bus.cxu_cmd_valid;
    prev_pay    = pay;
    cmd_cnt = bus.cxu_cmd_valid ? cmd_cnt + 1 : 0;
    bus.cxu_cmd_ready = bus.cxu_cmd_valid && (cmd_cnt > cmd_delay);
    rsp_cnt = bus.cxu_rsp_ready ? rsp_cnt + 1 : 0;
    bus.cxu_rsp_valid = bus.cxu_rsp_ready ? (rsp_cnt > rsp_delay) : spurious;
  end

  // Reference model
  logic [31:0] m_hash;
  logic [7:0]  m_win[$];

  task automatic model_reset();
    m_hash = '0;
    m_win.delete();
  endtask

  task automatic model_step(input logic [7:0] b, input logic l,
                            output logic [HB-1:0] eh, output logic [31:0] es, output logic eb);
    m_hash = ((m_hash << SH) ^ {24'h0, b}) & MASK;
    m_win.push_back(b);
    if (m_win.size() > W) void'(m_win.pop_front());
    es = 0;
    foreach (m_win[i]) es += {24'h0, m_win[i]};
    eb = (m_win.size() == W) && ((es % W) == 0);
    eh = m_hash[HB-1:0];
    if (l) model_reset();
  endtask

  // Pushes one byte and collects its result; err flags timeouts, unstable outputs,
  // in_ready outside IDLE, or a second out_valid.
  task automatic run_byte(input logic [7:0] b, input logic l, input int ostall,
                          output logic [HB-1:0] h, output logic [31:0] s, output logic bd,
                          output logic lo, output int vlat, output int rlat, output bit err);
    int k;
    err = 1'b0;
    k = 0;
    while (!bus.in_ready && k < 100) begin @(posedge clk); #1; k++; end
    if (!bus.in_ready) err = 1'b1;
    bus.in_valid = 1'b1; bus.in_byte = b; bus.in_last = l; bus.out_ready = (ostall == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_byte = 8'h00; bus.in_last = 1'b0;
    vlat = 1;
    while (!bus.out_valid && vlat < 200) begin
      if (bus.in_ready) err = 1'b1;
      @(posedge clk); #1; vlat++;
    end
    if (!bus.out_valid) err = 1'b1;
    h = bus.out_hash; s = bus.out_sum; bd = bus.out_boundary; lo = bus.out_last;
    for (int i = 0; i < ostall; i++) begin
      @(posedge clk); #1;
      if (!bus.out_valid || bus.in_ready || bus.out_hash !== h || bus.out_sum !== s ||
          bus.out_boundary !== bd || bus.out_last !== lo) err = 1'b1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rlat = vlat + ostall + 1;
    if (!bus.in_ready || bus.out_valid) err = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.cxu_cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid got %b want 0", bus.cxu_cmd_valid); else pass_cnt++;
    total_cnt++; if (bus.cxu_rsp_ready !== 1'b0) $display("FAIL reset_rsp_ready got %b want 0", bus.cxu_rsp_ready); else pass_cnt++;
    total_cnt++; if ({bus.out_hash, bus.out_sum, bus.out_boundary, bus.out_last} !== '0)
      $display("FAIL reset_out_data got %h/%h/%b/%b want 0", bus.out_hash, bus.out_sum, bus.out_boundary, bus.out_last); else pass_cnt++;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_two_byte(input string tag, input int cd, input int rd, input int os);
    logic [HB-1:0] h; logic [31:0] s; logic bd, lo; int vl, rl; bit err; int pe0;
    cmd_delay = cd; rsp_delay = rd;
    pe0 = pay_err;
    run_byte(8'h41, 1'b0, os, h, s, bd, lo, vl, rl, err);
    total_cnt++; if (err) $display("FAIL %s_b1_protocol got err=1 want 0", tag); else pass_cnt++;
    total_cnt++; if (h !== 15'h041 || s !== 32'h41 || lo !== 1'b0)
      $display("FAIL %s_b1 got %h/%h/%b want 041/41/0", tag, h, s, lo); else pass_cnt++;
    run_byte(8'h42, 1'b1, os, h, s, bd, lo, vl, rl, err);
    total_cnt++; if (err) $display("FAIL %s_b2_protocol got err=1 want 0", tag); else pass_cnt++;
    total_cnt++; if (h !== 15'h862 || s !== 32'h83 || lo !== 1'b1 || bd !== 1'b0)
      $display("FAIL %s_b2 got %h/%h/%b/%b want 862/83/1/0", tag, h, s, lo, bd); else pass_cnt++;
    run_byte(8'h01, 1'b1, os, h, s, bd, lo, vl, rl, err);
    total_cnt++; if (h !== 15'h001 || s !== 32'h01 || err)
      $display("FAIL %s_restart got %h/%h err=%0d want 001/01 err=0", tag, h, s, err); else pass_cnt++;
    total_cnt++; if (pay_err !== pe0) $display("FAIL %s_payload_hold got %0d changes want 0", tag, pay_err - pe0); else pass_cnt++;
    cmd_delay = 0; rsp_delay = 0;
  endtask

  task automatic test_window_boundary();
    logic [HB-1:0] h; logic [31:0] s; logic bd, lo; int vl, rl; bit err;
    int exp_s[5] = '{1, 2, 3, 4, 4};
    logic exp_b[5] = '{0, 0, 0, 1, 1};
    for (int i = 0; i < 5; i++) begin
      run_byte(8'h01, i == 4, 0, h, s, bd, lo, vl, rl, err);
      total_cnt++; if (s !== 32'(exp_s[i]) || bd !== exp_b[i] || err)
        $display("FAIL window_byte%0d got sum %0d bnd %b err %0d want sum %0d bnd %b", i, s, bd, err, exp_s[i], exp_b[i]); else pass_cnt++;
    end
    run_byte(8'h04, 1'b1, 0, h, s, bd, lo, vl, rl, err);
    total_cnt++; if (s !== 32'h4 || bd !== 1'b0)
      $display("FAIL boundary_unfilled got sum %0d bnd %b want 4/0", s, bd); else pass_cnt++;
  endtask

  task automatic test_latency();
    logic [HB-1:0] h; logic [31:0] s; logic bd, lo; int vl, rl; bit err;
    run_byte(8'h10, 1'b1, 0, h, s, bd, lo, vl, rl, err);
    total_cnt++; if (vl !== 5) $display("FAIL latency_out_valid got %0d want 5", vl); else pass_cnt++;
    total_cnt++; if (rl !== 6) $display("FAIL latency_in_ready got %0d want 6", rl); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [HB-1:0] h; logic [31:0] s; logic bd, lo; int vl, rl; bit err; int k; int seen;
    bus.in_valid = 1'b1; bus.in_byte = 8'h33; bus.in_last = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    k = 0;
    while (!(bus.cxu_rsp_ready && bus.cxu_cmd_function_id == 3'd1) && k < 50) begin @(posedge clk); #1; k++; end
    total_cnt++; if (k >= 50) $display("FAIL reset_mid_reach_roll_rsp got timeout want ROLL_RSP"); else pass_cnt++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total_cnt++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.cxu_cmd_valid !== 1'b0)
      $display("FAIL reset_mid_idle got in_ready %b out_valid %b cmd_valid %b want 1/0/0", bus.in_ready, bus.out_valid, bus.cxu_cmd_valid); else pass_cnt++;
    seen = 0;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; if (bus.out_valid) seen++; end
    total_cnt++; if (seen !== 0) $display("FAIL reset_mid_no_output got %0d outputs want 0", seen); else pass_cnt++;
    model_reset();
    run_byte(8'h05, 1'b1, 0, h, s, bd, lo, vl, rl, err);
    total_cnt++; if (h !== 15'h005 || s !== 32'h05 || err)
      $display("FAIL reset_mid_next got %h/%h err %0d want 005/05 err 0", h, s, err); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [HB-1:0] h, eh; logic [31:0] s, es; logic bd, eb, lo; int vl, rl; bit err;
    logic [7:0] b; logic l;
    model_reset();
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom_range(0, 255));
      l = (n == 39) || ($urandom_range(0, 5) == 0);
      cmd_delay = $urandom_range(0, 3);
      rsp_delay = $urandom_range(0, 3);
      spurious  = $urandom_range(0, 1) == 1;
      run_byte(b, l, $urandom_range(0, 3), h, s, bd, lo, vl, rl, err);
      model_step(b, l, eh, es, eb);
      total_cnt++; if (err) $display("FAIL rand%0d_protocol got err=1 want 0", n); else pass_cnt++;
      total_cnt++; if (h !== eh) $display("FAIL rand%0d_hash got %h want %h", n, h, eh); else pass_cnt++;
      total_cnt++; if (s !== es) $display("FAIL rand%0d_sum got %h want %h", n, s, es); else pass_cnt++;
      total_cnt++; if (bd !== eb || lo !== l) $display("FAIL rand%0d_flags got bnd %b last %b want %b %b", n, bd, lo, eb, l); else pass_cnt++;
    end
    total_cnt++; if (pay_err !== 0) $display("FAIL rand_payload_hold got %0d changes want 0", pay_err); else pass_cnt++;
    cmd_delay = 0; rsp_delay = 0; spurious = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_byte = 8'h00; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    bus.cxu_cmd_ready = 1'b0; bus.cxu_rsp_valid = 1'b0;
    test_reset();
    test_two_byte("zero_wait", 0, 0, 0);
    test_window_boundary();
    test_latency();
    test_two_byte("stalled", 3, 2, 4);
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
